// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle control sequencer for the SISC datapath: walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives every datapath enable.
module sisc_ctrl_fsm #(
    parameter int IR_W   = 32,
    parameter int STAT_W = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [IR_W-1:0]   ir,
    input  logic [STAT_W-1:0] stat,
    output logic              ir_load,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              br_sel,
    output logic [1:0]        alu_op,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              dm_we,
    output logic              stat_en,
    output logic              halted
);

    localparam logic [2:0] S_START     = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU_R = 4'h1;
    localparam logic [3:0] OP_ALU_I = 4'h2;
    localparam logic [3:0] OP_BRA   = 4'h4;
    localparam logic [3:0] OP_BRR   = 4'h5;
    localparam logic [3:0] OP_BNE   = 4'h6;
    localparam logic [3:0] OP_LOD   = 4'h8;
    localparam logic [3:0] OP_STR   = 4'h9;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [1:0] ALU_REG_REG = 2'b00;
    localparam logic [1:0] ALU_REG_IMM = 2'b01;
    localparam logic [1:0] ALU_ADDR    = 2'b10;
    localparam logic [1:0] ALU_PASS    = 2'b11;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [3:0]        r_opcode;
    logic [3:0]        w_opcode;
    logic [STAT_W-1:0] w_mm;
    logic              w_flag_hit;
    logic              w_taken;
    logic              w_unused_ir;

    assign w_opcode    = ir[IR_W-1 -: 4];
    assign w_mm        = ir[IR_W-5 -: STAT_W];
    assign w_flag_hit  = |(stat & w_mm);
    assign w_unused_ir = ^ir[IR_W-5-STAT_W:0];

    function automatic logic [1:0] alu_op_for(input logic [3:0] op);
        case (op)
            OP_ALU_R:       alu_op_for = ALU_REG_REG;
            OP_ALU_I:       alu_op_for = ALU_REG_IMM;
            OP_LOD, OP_STR: alu_op_for = ALU_ADDR;
            default:        alu_op_for = ALU_PASS;
        endcase
    endfunction

    // stat only reaches the control path here, and only while in DECODE.
    always_comb begin
        case (w_opcode)
            OP_BRA, OP_BRR: w_taken = w_flag_hit;
            OP_BNE:         w_taken = !w_flag_hit;
            default:        w_taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_START:  w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ALU_R, OP_ALU_I, OP_LOD, OP_STR: w_next_state = S_EXECUTE;
                    OP_HLT:                             w_next_state = S_HALT;
                    default:                            w_next_state = S_FETCH;
                endcase
            end
            S_EXECUTE: begin
                if (r_opcode == OP_LOD || r_opcode == OP_STR) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WRITEBACK;
                end
            end
            S_MEM:       w_next_state = (r_opcode == OP_LOD) ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: w_next_state = S_FETCH;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_START;
        endcase
    end

    // The opcode is captured in DECODE so later states ignore any IR churn.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (rst_f) begin
            r_state  <= S_START;
            r_opcode <= OP_NOP;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_opcode <= w_opcode;
            end
        end
    end

    always_comb begin
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        alu_op   = 2'b00;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        dm_we    = 1'b0;
        stat_en  = 1'b0;
        halted   = 1'b0;
        // Reset silences every output immediately, whatever state is still held.
        if (!rst_f) begin
            case (r_state)
                S_FETCH: begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    alu_op = alu_op_for(w_opcode);
                    if (w_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = (w_opcode == OP_BRA);
                    end
                end
                S_EXECUTE: begin
                    alu_op  = alu_op_for(r_opcode);
                    stat_en = (r_opcode == OP_ALU_R) || (r_opcode == OP_ALU_I);
                end
                S_MEM: begin
                    alu_op = alu_op_for(r_opcode);
                    dm_we  = (r_opcode == OP_STR);
                end
                S_WRITEBACK: begin
                    alu_op = alu_op_for(r_opcode);
                    rf_we  = 1'b1;
                    wb_sel = (r_opcode == OP_LOD);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Directed bench for sisc_ctrl_fsm: walks each instruction class state by state
// and compares the packed control outputs against hand-computed vectors.
module tb_sisc_ctrl_fsm;

    logic        clk;
    logic        rst_f;
    logic [31:0] ir;
    logic [3:0]  stat;
    logic        ir_load, pc_write, pc_sel, br_sel;
    logic [1:0]  alu_op;
    logic        rf_we, wb_sel, dm_we, stat_en, halted;

    int n_checks = 0;
    int n_fail   = 0;

    sisc_ctrl_fsm #(.IR_W(32), .STAT_W(4)) dut (
        .clk(clk), .rst_f(rst_f), .ir(ir), .stat(stat),
        .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
        .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .dm_we(dm_we),
        .stat_en(stat_en), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir_load, pc_write, pc_sel, br_sel, alu_op[1:0], rf_we, wb_sel, dm_we, stat_en, halted}
    logic [10:0] w_obs;
    assign w_obs = {ir_load, pc_write, pc_sel, br_sel, alu_op, rf_we, wb_sel, dm_we, stat_en, halted};

    localparam logic [10:0] O_ZERO      = 11'b000_0_00_0_0_0_0_0;
    localparam logic [10:0] O_FETCH     = 11'b110_0_00_0_0_0_0_0;
    localparam logic [10:0] O_DEC_RR    = 11'b000_0_00_0_0_0_0_0;
    localparam logic [10:0] O_DEC_RI    = 11'b000_0_01_0_0_0_0_0;
    localparam logic [10:0] O_DEC_ADDR  = 11'b000_0_10_0_0_0_0_0;
    localparam logic [10:0] O_DEC_PASS  = 11'b000_0_11_0_0_0_0_0;
    localparam logic [10:0] O_DEC_REL_T = 11'b011_0_11_0_0_0_0_0;
    localparam logic [10:0] O_DEC_ABS_T = 11'b011_1_11_0_0_0_0_0;
    localparam logic [10:0] O_EX_R      = 11'b000_0_00_0_0_0_1_0;
    localparam logic [10:0] O_EX_I      = 11'b000_0_01_0_0_0_1_0;
    localparam logic [10:0] O_EX_ADDR   = 11'b000_0_10_0_0_0_0_0;
    localparam logic [10:0] O_MEM_LOD   = 11'b000_0_10_0_0_0_0_0;
    localparam logic [10:0] O_MEM_STR   = 11'b000_0_10_0_0_1_0_0;
    localparam logic [10:0] O_WB_R      = 11'b000_0_00_1_0_0_0_0;
    localparam logic [10:0] O_WB_I      = 11'b000_0_01_1_0_0_0_0;
    localparam logic [10:0] O_WB_LOD    = 11'b000_0_10_1_1_0_0_0;
    localparam logic [10:0] O_HALT      = 11'b000_0_00_0_0_0_0_1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [10:0] expected);
        n_checks++;
        assert (w_obs === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, w_obs, expected);
        end
    endtask

    initial begin
        rst_f = 1'b1;
        ir    = 32'h0000_0000;
        stat  = 4'b0000;
        tick();
        tick();
        check("reset_idle", O_ZERO);

        // ALU_R: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH (4 cycles)
        rst_f = 1'b0;
        ir    = 32'h1123_0000;
        tick(); check("alur_fetch", O_FETCH);
        tick(); check("alur_decode", O_DEC_RR);
        tick(); check("alur_exec", O_EX_R);
        tick(); check("alur_wb", O_WB_R);
        tick(); check("alur_next_fetch", O_FETCH);

        // ALU_I, with a stat change in EXECUTE that must not matter
        ir = 32'h2123_0005;
        tick(); check("alui_decode", O_DEC_RI);
        stat = 4'b1111;
        tick(); check("alui_exec", O_EX_I);
        tick(); check("alui_wb", O_WB_I);
        stat = 4'b0000;
        tick(); check("alui_next_fetch", O_FETCH);

        // LOD: 5-cycle loop, write-back from dmem
        ir = 32'h8012_0004;
        tick(); check("lod_decode", O_DEC_ADDR);
        tick(); check("lod_exec", O_EX_ADDR);
        tick(); check("lod_mem", O_MEM_LOD);
        tick(); check("lod_wb", O_WB_LOD);
        tick(); check("lod_next_fetch", O_FETCH);

        // STR: single dm_we in MEM, no register write
        ir = 32'h9012_0004;
        tick(); check("str_decode", O_DEC_ADDR);
        tick(); check("str_exec", O_EX_ADDR);
        tick(); check("str_mem", O_MEM_STR);
        tick(); check("str_next_fetch", O_FETCH);

        // BRR taken / untaken
        ir   = 32'h5100_0003;
        stat = 4'b0001;
        tick(); check("brr_taken_decode", O_DEC_REL_T);
        tick(); check("brr_taken_fetch", O_FETCH);
        stat = 4'b0000;
        tick(); check("brr_untaken_decode", O_DEC_PASS);
        tick(); check("brr_untaken_fetch", O_FETCH);

        // BNE taken when no selected flag, untaken when one is set
        ir   = 32'h6100_0002;
        stat = 4'b0000;
        tick(); check("bne_taken_decode", O_DEC_REL_T);
        tick(); check("bne_taken_fetch", O_FETCH);
        stat = 4'b0001;
        tick(); check("bne_untaken_decode", O_DEC_PASS);
        tick(); check("bne_untaken_fetch", O_FETCH);

        // BRA taken (absolute), then with a flag outside the mask
        ir   = 32'h4200_0010;
        stat = 4'b0010;
        tick(); check("bra_taken_decode", O_DEC_ABS_T);
        tick(); check("bra_taken_fetch", O_FETCH);
        stat = 4'b1101;
        tick(); check("bra_untaken_decode", O_DEC_PASS);
        tick(); check("bra_untaken_fetch", O_FETCH);

        // Illegal opcode behaves as NOP
        ir   = 32'h3000_0000;
        stat = 4'b0000;
        tick(); check("illegal_decode", O_DEC_PASS);
        tick(); check("illegal_fetch", O_FETCH);

        // Reset during EXECUTE of ALU_R
        ir = 32'h1123_0000;
        tick(); check("rstmid_decode", O_DEC_RR);
        tick(); check("rstmid_exec", O_EX_R);
        rst_f = 1'b1;
        #1; check("rstmid_held_zero", O_ZERO);
        tick(); check("rstmid_start", O_ZERO);
        rst_f = 1'b0;
        tick(); check("rstmid_fetch", O_FETCH);

        // HLT: halted sticks with no enables
        ir = 32'hF000_0000;
        tick(); check("hlt_decode", O_DEC_PASS);
        for (int i = 0; i < 20; i++) begin
            if (i == 7) stat = 4'b1111;
            if (i == 13) ir = 32'h1123_0000;
            tick(); check("hlt_halted", O_HALT);
        end
        rst_f = 1'b1;
        tick(); check("hlt_reset_start", O_ZERO);
        rst_f = 1'b0;
        tick(); check("hlt_after_reset_fetch", O_FETCH);
        tick(); check("hlt_after_reset_decode", O_DEC_RR);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sisc_ctrl_fsm.md
Name: sisc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the SISC datapath. It is the single source of PC_WRITE, PC_SEL, BR_SEL, ALU_OP, register-file write and data-memory strobes. It steps each instruction through FETCH→DECODE→EXECUTE→MEM→WRITEBACK, using the IR held in the datapath and the ALU status flags. It sits between the instruction register and the pc/rf/alu/dm units inside sisc.

Parameters:
IR_W, 32, instruction register width
STAT_W, 4, status flag width (C,N,V,Z = bits 3..0)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_f  in  1  reset, synchronous, active-high
ir  in  IR_W  current instruction; opcode ir[31:28], mm ir[27:24]
stat  in  STAT_W  registered ALU status flags
ir_load  out  1  latch instruction memory into IR
pc_write  out  1  PC register load enable
pc_sel  out  1  0 = pc+1, 1 = branch target
br_sel  out  1  0 = relative (pc+1+imm), 1 = absolute (imm)
alu_op  out  2  00 = reg/reg using mm, 01 = reg/imm, 10 = address calc (add imm), 11 = pass/none
rf_we  out  1  register-file write enable
wb_sel  out  1  0 = ALU result, 1 = dmem read data
dm_we  out  1  data-memory write enable
stat_en  out  1  update status register
halted  out  1  processor in HALT

Behaviour:
- Opcodes: 0 NOP, 1 ALU_R, 2 ALU_I, 4 BRA (absolute, cond), 5 BRR (relative, cond), 6 BNE (relative, taken when no selected flag set), 8 LOD, 9 STR, F HLT. Any other opcode is treated as NOP.
- States: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Encoding is free.
- rst_f high at a clock edge → state START. All outputs 0 while rst_f is high and in START. Reset overrides any state, including HALT and an in-flight instruction.
- START→FETCH unconditionally (one idle cycle after reset).
- FETCH: ir_load=1, pc_write=1, pc_sel=0. Next state DECODE.
- DECODE: outputs 0 except alu_op per opcode.
  - Branch taken condition: (stat & mm) != 0 for BRA/BRR; (stat & mm) == 0 for BNE.
  - Taken branch: pc_write=1, pc_sel=1, br_sel=1 for BRA and 0 for BRR/BNE. Next state FETCH.
  - Untaken branch or NOP: next state FETCH with no writes.
  - HLT: next state HALT.
  - All others: next state EXECUTE.
- EXECUTE:
  - ALU_R: alu_op=00, stat_en=1.
  - ALU_I: alu_op=01, stat_en=1.
  - LOD/STR: alu_op=10, stat_en=0.
  - Next state MEM for LOD/STR, else WRITEBACK.
- MEM:
  - STR: dm_we=1 for exactly one cycle, next state FETCH.
  - LOD: next state WRITEBACK.
- WRITEBACK: rf_we=1 for exactly one cycle. wb_sel=1 for LOD, 0 otherwise. alu_op is held from EXECUTE. Next state FETCH.
- HALT: halted=1, all enables 0. Stays in HALT until reset.
- Outputs are Moore-decoded from state plus registered ir/stat, with no combinational path from stat to the state register except in DECODE.
- Latencies (FETCH to next FETCH):
  - NOP or branch: 2 cycles.
  - STR: 4 cycles.
  - ALU_R / ALU_I: 4 cycles.
  - LOD: 5 cycles.
- stat is sampled in DECODE only. A stat change in any other state has no effect.
- One-hot invariant: at most one of pc_write, rf_we, dm_we is high in any cycle, except FETCH (pc_write + ir_load).

Test Plan:
- Reset mid-instruction: assert rst_f during EXECUTE of ALU_R (ir=32'h1123_0000) → next cycle state START, all outputs 0. One cycle after release → ir_load=1, pc_write=1, pc_sel=0.
- ALU_R: ir=32'h1123_0000 → DECODE alu_op=00. EXECUTE stat_en=1. WRITEBACK rf_we=1, wb_sel=0. FETCH reached 4 cycles after the previous FETCH.
- LOD then STR:
  - ir=32'h8012_0004 → EXECUTE alu_op=10. MEM dm_we=0. WRITEBACK rf_we=1, wb_sel=1. Total 5 cycles.
  - ir=32'h9012_0004 → dm_we=1 for exactly one cycle in MEM, rf_we never asserted.
- Conditional branches:
  - BRR ir=32'h5100_0003 with stat=4'b0001 → DECODE pc_write=1, pc_sel=1, br_sel=0.
  - Same ir with stat=4'b0000 → no pc_write in DECODE, FETCH next.
- BNE/BRA: BNE ir=32'h6100_0002 with stat=4'b0000 → taken (pc_sel=1, br_sel=0). BRA ir=32'h4200_0010 with stat=4'b0010 → pc_sel=1, br_sel=1.
- Halt and illegal opcode:
  - ir=32'hF000_0000 → halted=1 from the cycle after DECODE onward, with no enables for 20 cycles. rst_f pulse → START then FETCH.
  - ir=32'h3000_0000 → behaves as NOP (2-cycle loop).
